// File: rtl/bit_serial_transmitter.sv
// Parallel-to-serial operand transmitter: loads a word through a valid/ready
// handshake and emits one bit per enabled cycle, flagging the final bit.
module bit_serial_transmitter #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  assign busy      = (state == SHIFT);
  assign bit_valid = busy;
  assign last      = busy && (cnt == LAST_CNT);
  // Shift register is zeroed whenever the state returns to IDLE; the gate keeps
  // bit_out quiet even so.
  assign bit_out   = busy && (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
  assign load_ready = !busy || (last && enable);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= load_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            if (cnt == LAST_CNT) begin
              // Final bit consumed: chain straight into the next word if offered
              if (load_valid) begin
                shreg <= load_data;
                cnt   <= '0;
              end else begin
                shreg <= '0;
                cnt   <= '0;
                state <= IDLE;
              end
            end else begin
              shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
              cnt   <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          shreg <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
